// File: rtl/hash_io_pkg.sv
// hash_io_pkg: shared FSM state and config word indices for the hash host port
package hash_io_pkg;
    typedef enum logic [1:0] {IDLE, ABSORB, BUSY} state_t;
    localparam int CFG_WORDS = 4;
    localparam logic [1:0] CFG_IDX_ID   = 2'd0;
    localparam logic [1:0] CFG_IDX_IOW  = 2'd1;
    localparam logic [1:0] CFG_IDX_RATE = 2'd2;
    localparam logic [1:0] CFG_IDX_DIG  = 2'd3;
endpackage

// File: rtl/hash_io_shreg.sv
// hash_io_shreg: W-bit register with parallel load and IO_W-bit left shift, exposing its top OUT_W bits
module hash_io_shreg
    import hash_io_pkg::*;
#(
    parameter int W     = 64,
    parameter int IO_W  = 16,
    parameter int OUT_W = W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ld,
    input  logic             sh,
    input  logic [IO_W-1:0]  din,
    input  logic [W-1:0]     pdata,
    output logic [OUT_W-1:0] q
);
    logic [W-1:0] st;
    logic [W-1:0] sh_v;
    generate
        if (W > IO_W) begin : g_wide
            assign sh_v = {st[W-IO_W-1:0], din};
        end else begin : g_narrow
            assign sh_v = din;
        end
    endgenerate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= '0;
        else if (clr) st <= '0;
        else if (ld) st <= pdata;
        else if (sh) st <= sh_v;
    end
    assign q = st[W-1 -: OUT_W];
endmodule

// File: rtl/hash_io_port.sv
// hash_io_port: host word packer/unpacker, core start/init sequencing, config readback and sticky error
module hash_io_port
    import hash_io_pkg::*;
#(
    parameter int          IO_W   = 16,
    parameter int          RATE   = 1088,
    parameter int          DIGEST = 256,
    parameter logic [15:0] CFG_ID = 16'hC0DE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic              load,
    input  logic              fetch,
    input  logic              getconfig,
    input  logic [IO_W-1:0]   idata,
    output logic              ack,
    output logic [IO_W-1:0]   odata,
    output logic              err,
    output logic              core_init,
    output logic              core_start,
    output logic [RATE-1:0]   core_block,
    input  logic              core_done,
    input  logic [DIGEST-1:0] core_digest
);
    localparam int NW = RATE / IO_W;
    localparam int ND = DIGEST / IO_W;
    localparam int WW = NW > 1 ? $clog2(NW) : 1;
    localparam int FW = ND > 1 ? $clog2(ND) : 1;
    generate
        if ((RATE % IO_W) != 0 || (DIGEST % IO_W) != 0) begin : g_bad_width
            $error("hash_io_port: RATE and DIGEST must be multiples of IO_W");
        end
    endgenerate
    state_t state, state_n;
    logic [WW-1:0] wcnt, wcnt_n;
    logic [FW-1:0] fcnt, fcnt_n;
    logic [1:0] ccnt, ccnt_n;
    logic dig_valid, dig_valid_n;
    logic ack_n, err_n, core_init_n, core_start_n;
    logic [IO_W-1:0] odata_n, dig_top, cfg_word;
    logic multi, do_load, do_fetch, do_cfg, cap, last;
    // Strobe decode: init overrides everything, colliding host strobes service nothing.
    assign multi    = (load & fetch) | (load & getconfig) | (fetch & getconfig);
    assign do_load  = ~init & ~multi & load & (state == ABSORB);
    assign do_fetch = ~init & ~multi & fetch & dig_valid;
    assign do_cfg   = ~init & ~multi & getconfig;
    assign cap      = ~init & (state == BUSY) & core_done;
    assign last     = wcnt == WW'(NW - 1);
    assign cfg_word = ccnt == CFG_IDX_ID   ? IO_W'(CFG_ID) :
                      ccnt == CFG_IDX_IOW  ? IO_W'(IO_W)   :
                      ccnt == CFG_IDX_RATE ? IO_W'(NW)     : IO_W'(ND);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = init ? ABSORB : (do_load & last) ? BUSY : cap ? ABSORB : state;
    end
    always_comb begin
        ack_n        = do_load | do_fetch | do_cfg;
        odata_n      = do_fetch ? dig_top : do_cfg ? cfg_word : '0;
        err_n        = ~init & (err | multi | (fetch & ~dig_valid));
        core_init_n  = init;
        core_start_n = do_load & last;
        wcnt_n       = init ? '0 : do_load ? (last ? '0 : wcnt + WW'(1)) : wcnt;
        fcnt_n       = (init | cap) ? '0 : do_fetch ? (fcnt == FW'(ND - 1) ? '0 : fcnt + FW'(1)) : fcnt;
        ccnt_n       = init ? '0 : do_cfg ? ccnt + 2'd1 : ccnt;
        dig_valid_n  = init ? 1'b0 : cap ? 1'b1 : do_load ? 1'b0 : dig_valid;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack        <= 1'b0;
            odata      <= '0;
            err        <= 1'b0;
            core_init  <= 1'b0;
            core_start <= 1'b0;
            wcnt       <= '0;
            fcnt       <= '0;
            ccnt       <= '0;
            dig_valid  <= 1'b0;
        end else begin
            ack        <= ack_n;
            odata      <= odata_n;
            err        <= err_n;
            core_init  <= core_init_n;
            core_start <= core_start_n;
            wcnt       <= wcnt_n;
            fcnt       <= fcnt_n;
            ccnt       <= ccnt_n;
            dig_valid  <= dig_valid_n;
        end
    end
    hash_io_shreg #(.W(RATE), .IO_W(IO_W), .OUT_W(RATE)) u_pack (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (init),
        .ld    (1'b0),
        .sh    (do_load),
        .din   (idata),
        .pdata ('0),
        .q     (core_block)
    );
    // Digest register rotates its top word back in, so fetches wrap around naturally.
    hash_io_shreg #(.W(DIGEST), .IO_W(IO_W), .OUT_W(IO_W)) u_unpack (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (init),
        .ld    (cap),
        .sh    (do_fetch),
        .din   (dig_top),
        .pdata (core_digest),
        .q     (dig_top)
    );
endmodule

// File: tb/tb_hash_io_port.sv
// tb_hash_io_port: directed and random host traffic against a transaction-level model with a stub core
module tb_hash_io_port;
    localparam int IO_W = 16, RATE = 64, DIGEST = 32;
    logic clk = 1'b0, rst_n = 1'b0, init = 1'b0, load = 1'b0, fetch = 1'b0, getconfig = 1'b0;
    logic [15:0] idata = '0;
    logic ack, err, core_init, core_start, core_done;
    logic [15:0] odata;
    logic [63:0] core_block;
    logic [31:0] core_digest;
    int vectors = 0, miscompares = 0;
    always #5 clk = ~clk;
    hash_io_port #(.IO_W(IO_W), .RATE(RATE), .DIGEST(DIGEST)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .init        (init),
        .load        (load),
        .fetch       (fetch),
        .getconfig   (getconfig),
        .idata       (idata),
        .ack         (ack),
        .odata       (odata),
        .err         (err),
        .core_init   (core_init),
        .core_start  (core_start),
        .core_block  (core_block),
        .core_done   (core_done),
        .core_digest (core_digest)
    );
    int dly;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly <= 0;
            core_done <= 1'b0;
            core_digest <= '0;
        end else begin
            core_done <= (dly == 1);
            dly <= core_start ? 5 : (dly > 0 ? dly - 1 : 0);
            if (core_start) core_digest <= core_block[63:32] ^ core_block[31:0];
        end
    end
    bit m_started, m_busy, m_dv, m_err;
    int m_fidx, m_cidx;
    logic [15:0] m_words[$];
    logic [15:0] m_dig[2];
    logic [15:0] m_pend[2];
    logic [15:0] cfg_tab[4] = '{16'hC0DE, 16'(IO_W), 16'(RATE / IO_W), 16'(DIGEST / IO_W)};
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic m_reset();
        m_started = 0; m_busy = 0; m_dv = 0; m_err = 0; m_fidx = 0; m_cidx = 0;
        m_words.delete();
    endtask
    task automatic step(input bit i, input bit l, input bit f, input bit g, input logic [15:0] d);
        bit e_ack, e_start, was_busy, done_now;
        logic [15:0] e_od;
        logic [63:0] e_blk;
        @(negedge clk);
        init = i; load = l; fetch = f; getconfig = g; idata = d;
        done_now = core_done;
        was_busy = m_busy;
        e_ack = 0; e_start = 0; e_od = '0; e_blk = '0;
        if (i) begin
            m_reset();
            m_started = 1;
        end else if (int'(l) + int'(f) + int'(g) > 1) m_err = 1;
        else if (l) begin
            if (m_started && !m_busy) begin
                e_ack = 1;
                m_dv = 0;
                m_words.push_back(d);
                if (m_words.size() == 4) begin
                    e_start = 1;
                    e_blk = {m_words[0], m_words[1], m_words[2], m_words[3]};
                    m_pend[0] = m_words[0] ^ m_words[2];
                    m_pend[1] = m_words[1] ^ m_words[3];
                    m_busy = 1;
                    m_words.delete();
                end
            end
        end else if (f) begin
            if (m_dv) begin
                e_ack = 1;
                e_od = m_dig[m_fidx];
                m_fidx = (m_fidx + 1) % 2;
            end else m_err = 1;
        end else if (g) begin
            e_ack = 1;
            e_od = cfg_tab[m_cidx];
            m_cidx = (m_cidx + 1) % 4;
        end
        if (!i && was_busy && done_now) begin
            m_busy = 0; m_dv = 1; m_fidx = 0; m_dig = m_pend;
        end
        @(posedge clk);
        #1;
        chk("ack", ack, e_ack);
        chk("err", err, m_err);
        chk("core_init", core_init, i);
        chk("core_start", core_start, e_start);
        if (e_ack && (f || g)) chk("odata", odata, e_od);
        if (e_start) chk("core_block", core_block, e_blk);
    endtask
    task automatic wait_done_loading(input logic [15:0] d);
        for (int k = 0; k < 20 && m_busy; k++) step(0, 1, 0, 0, d);
        vectors++;
        if (m_busy) begin
            miscompares++;
            $error("FAIL done_timeout: observed busy=1 expected busy=0");
        end
    endtask
    task automatic check_reset_state();
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_odata", odata, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_init", core_init, 0);
        chk("rst_core_block", core_block, 0);
    endtask
    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;
        repeat (5) step(0, 0, 0, 1, '0);
        step(1, 0, 0, 0, '0);
        step(0, 1, 0, 0, 16'h1111);
        step(0, 1, 0, 0, 16'h2222);
        step(0, 1, 0, 0, 16'h3333);
        step(0, 1, 0, 0, 16'h4444);
        wait_done_loading(16'h5555);
        repeat (3) step(0, 0, 1, 0, '0);
        step(1, 0, 0, 0, '0);
        step(0, 0, 1, 0, '0);
        step(1, 0, 0, 0, '0);
        step(0, 1, 1, 0, 16'hAAAA);
        step(0, 1, 0, 0, 16'h0101);
        step(0, 1, 0, 0, 16'h0202);
        step(0, 0, 1, 1, '0);
        step(0, 1, 0, 0, 16'h0303);
        step(1, 1, 0, 0, 16'hBEEF);
        step(0, 1, 0, 0, 16'hA1A1);
        step(0, 1, 0, 0, 16'hB2B2);
        @(negedge clk);
        init = 0; load = 0; fetch = 0; getconfig = 0;
        rst_n = 1'b0;
        #1;
        check_reset_state();
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 0, 0, 16'hDEAD);
        step(0, 0, 0, 1, '0);
        step(1, 0, 0, 0, '0);
        step(0, 1, 0, 0, 16'h1234);
        step(0, 1, 0, 0, 16'h5678);
        step(0, 1, 0, 0, 16'h9ABC);
        step(0, 1, 0, 0, 16'hDEF0);
        wait_done_loading(16'h7777);
        repeat (2) step(0, 0, 1, 0, '0);
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 15, 16'($urandom));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
